// File: rtl/btn_bouncer_pkg.sv
// Shared definitions for the mechanical-switch emulator: FSM encoding,
// LFSR polynomial and counter widths.
package btn_bouncer_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        BOUNCE = 1'b1
    } state_e;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam int          WINDOW_W  = 16;

endpackage

// File: rtl/btn_bouncer_if.sv
// Request/response bundle between a bouncer and whatever drives it:
// valid/ready request handshake plus the emulated button and settle pulse.
interface btn_bouncer_if;

    logic i_req_valid;
    logic i_req_level;
    logic o_req_ready;
    logic o_btn;
    logic o_done;

    modport master (
        output i_req_valid,
        output i_req_level,
        input  o_req_ready,
        input  o_btn,
        input  o_done
    );

    modport slave (
        input  i_req_valid,
        input  i_req_level,
        output o_req_ready,
        output o_btn,
        output o_done
    );

endinterface

// File: rtl/bouncer_lfsr16.sv
// 16-bit Galois LFSR that advances only when i_step is high; reloads SEED
// solely on reset so chatter differs from one request to the next.
module bouncer_lfsr16
    import btn_bouncer_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_step,
    output logic [15:0] o_state
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [15:0] shifted;

    // Each bit takes its upper neighbour, XORed with the feedback bit where
    // the polynomial has a tap; the top bit has no neighbour.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_tap
            if (gi == 15) begin : g_top
                assign shifted[gi] = LFSR_POLY[gi] & lfsr_q[0];
            end else begin : g_mid
                assign shifted[gi] = lfsr_q[gi+1] ^ (LFSR_POLY[gi] & lfsr_q[0]);
            end
        end
    endgenerate

    assign lfsr_d = i_step ? shifted : lfsr_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_state = lfsr_q;

endmodule

// File: rtl/btn_bouncer.sv
// Switch emulator: on request, chatters o_btn at pseudo-random intervals for
// BOUNCE_CYCLES clocks, then forces the requested level and pulses o_done.
module btn_bouncer
    import btn_bouncer_pkg::*;
#(
    parameter int          BOUNCE_CYCLES = 50000,
    parameter int          GAP_LOG2      = 10,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    btn_bouncer_if.slave  bus
);

    localparam logic [WINDOW_W-1:0] WINDOW_LOAD = WINDOW_W'(BOUNCE_CYCLES - 1);

    state_e                state_q, state_d;
    logic [WINDOW_W-1:0]   window_q, window_d;
    logic [GAP_LOG2-1:0]   gap_q, gap_d;
    logic                  target_q, target_d;
    logic                  btn_q, btn_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;

    logic                  lfsr_step;
    logic [15:0]           lfsr_state;
    logic [GAP_LOG2-1:0]   gap_seed;
    logic                  accept;
    logic                  unused_lfsr_bits;

    bouncer_lfsr16 #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_step  (lfsr_step),
        .o_state (lfsr_state)
    );

    assign gap_seed         = lfsr_state[GAP_LOG2-1:0];
    assign unused_lfsr_bits = ^lfsr_state[15:GAP_LOG2];

    // ready_q is only ever high in IDLE, so it alone qualifies acceptance.
    assign accept = bus.i_req_valid && ready_q;

    always_comb begin
        state_d   = state_q;
        window_d  = window_q;
        gap_d     = gap_q;
        target_d  = target_q;
        btn_d     = btn_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        lfsr_step = 1'b0;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    target_d = bus.i_req_level;
                    ready_d  = 1'b0;
                    if (bus.i_req_level != btn_q) begin
                        btn_d     = ~btn_q;
                        window_d  = WINDOW_LOAD;
                        gap_d     = gap_seed;
                        lfsr_step = 1'b1;
                        state_d   = BOUNCE;
                    end else begin
                        // Already at the requested level: acknowledge only.
                        done_d = 1'b1;
                    end
                end
            end

            BOUNCE: begin
                ready_d = 1'b0;
                if (window_q == '0) begin
                    // Forced final edge fixes the level whatever the toggle parity.
                    btn_d   = target_q;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else if (gap_q == '0) begin
                    btn_d     = ~btn_q;
                    gap_d     = gap_seed;
                    lfsr_step = 1'b1;
                    window_d  = window_q - WINDOW_W'(1);
                end else begin
                    gap_d    = gap_q - GAP_LOG2'(1);
                    window_d = window_q - WINDOW_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            window_q <= '0;
            gap_q    <= '0;
            target_q <= 1'b0;
            btn_q    <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            gap_q    <= gap_d;
            target_q <= target_d;
            btn_q    <= btn_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign bus.o_req_ready = ready_q;
    assign bus.o_btn       = btn_q;
    assign bus.o_done      = done_q;

endmodule

// File: tb/tb_btn_bouncer.sv
// Scoreboarded bench for btn_bouncer: directed requests with hand-computed
// latencies and chatter prefixes, a reference trace model, and a closed loop.
module tb_btn_bouncer;

    localparam int BC  = 16;
    localparam int G   = 2;
    localparam int BC2 = 1000;
    localparam int G2  = 4;
    localparam int TP  = 1100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btn_bouncer_if bif ();
    btn_bouncer_if bif2 ();
    btn_bouncer_if bif3 ();

    btn_bouncer #(.BOUNCE_CYCLES(BC), .GAP_LOG2(G), .LFSR_SEED(16'hACE1))
        u_dut (.i_clk(clk), .i_reset(rst), .bus(bif));
    btn_bouncer #(.BOUNCE_CYCLES(BC2), .GAP_LOG2(G2), .LFSR_SEED(16'hACE1))
        u_dut2 (.i_clk(clk), .i_reset(rst), .bus(bif2));
    btn_bouncer #(.BOUNCE_CYCLES(1), .GAP_LOG2(1), .LFSR_SEED(16'hACE1))
        u_dut3 (.i_clk(clk), .i_reset(rst), .bus(bif3));

    typedef struct {
        logic        level;
        int          latency;
        int          toggles;
        logic [63:0] trace;
        logic        chk_head;
        logic [5:0]  head;
    } exp_t;

    exp_t sb_q[$];
    logic deb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [15:0] m_lfsr = 16'hACE1;
    logic        m_btn  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        ref_step = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Reference trace of o_btn sampled once per cycle from accept+1 to the done cycle.
    task automatic model_req(input logic lvl, output exp_t e);
        logic [63:0] tr;
        int          tog, gap, window, cyc;
        logic        b, prev;
        tr = '0; tog = 0; cyc = 0;
        e.level = lvl; e.chk_head = 1'b0; e.head = '0; e.latency = 0;
        if (lvl == m_btn) begin
            tr[0] = m_btn;
            e.toggles = 0;
            e.trace = tr;
            return;
        end
        b = ~m_btn;
        gap = int'(m_lfsr[G-1:0]);
        m_lfsr = ref_step(m_lfsr);
        window = BC - 1;
        tr[0] = b; tog = 1; cyc = 1;
        for (int k = 1; k <= BC; k++) begin
            prev = b;
            if (window == 0) begin
                b = lvl;
            end else if (gap == 0) begin
                b = ~b;
                gap = int'(m_lfsr[G-1:0]);
                m_lfsr = ref_step(m_lfsr);
                window--;
            end else begin
                gap--;
                window--;
            end
            tr[cyc] = b;
            cyc++;
            if (b != prev) tog++;
        end
        m_btn = lvl;
        e.toggles = tog;
        e.trace = tr;
    endtask

    // Monitor: detects acceptance at the edge, samples mid-cycle, scores on o_done.
    initial begin : monitor
        logic        acc, active, last_btn, settled;
        int          cyc, tog, run, max_run, ready_hi;
        logic [63:0] tr;
        exp_t        e;
        active = 1'b0; last_btn = 1'b0; settled = 1'b0;
        cyc = 0; tog = 0; run = 0; max_run = 0; ready_hi = 0; tr = '0;
        forever begin
            @(posedge clk);
            acc = bif.i_req_valid && bif.o_req_ready && !rst;
            @(negedge clk);
            if (rst) begin
                active = 1'b0; settled = 1'b0; last_btn = 1'b0;
            end else begin
                if (acc) begin
                    active = 1'b1; cyc = 0; tog = 0; run = 0; max_run = 0; ready_hi = 0; tr = '0;
                end
                if (active) begin
                    cyc++;
                    if (bif.o_btn != last_btn) begin tog++; run = 1; end else run++;
                    if (cyc <= 64) tr[cyc-1] = bif.o_btn;
                    if (!bif.o_done) begin
                        if (run > max_run) max_run = run;
                        if (bif.o_req_ready) ready_hi++;
                    end else if (sb_q.size() == 0) begin
                        check("unexpected_done", bif.o_done, 0);
                        active = 1'b0; settled = bif.o_btn;
                    end else begin
                        e = sb_q.pop_front();
                        check("settled_level", bif.o_btn, e.level);
                        check("done_latency", cyc, e.latency);
                        check("toggle_count", tog, e.toggles);
                        check("btn_trace", tr, e.trace);
                        check("ready_low_in_window", ready_hi, 0);
                        check("ready_at_done", bif.o_req_ready, e.latency != 1);
                        if (e.toggles > 0) check("max_run_le_gap", max_run <= (1 << G), 1);
                        if (e.chk_head) check("chatter_head", tr[5:0], e.head);
                        $display("[%0t] req level=%0b latency=%0d toggles=%0d max_run=%0d",
                                 $time, e.level, cyc, tog, max_run);
                        active = 1'b0; settled = bif.o_btn;
                    end
                end else begin
                    check("idle_btn_stable", bif.o_btn, settled);
                    check("idle_no_done", bif.o_done, 0);
                end
                last_btn = bif.o_btn;
            end
        end
    end

    // Behavioural debouncer fed by the second bouncer.
    logic deb;
    int   deb_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            deb     <= 1'b0;
            deb_cnt <= 0;
        end else if (bif2.o_btn == deb) begin
            deb_cnt <= 0;
        end else if (deb_cnt == TP - 1) begin
            deb     <= bif2.o_btn;
            deb_cnt <= 0;
        end else begin
            deb_cnt <= deb_cnt + 1;
        end
    end

    int deb_changes = 0;
    initial begin : deb_monitor
        logic deb_prev;
        logic exp_lvl;
        deb_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (deb !== deb_prev) begin
                deb_changes++;
                if (deb_q.size() == 0) begin
                    check("deb_unexpected_change", deb, deb_prev);
                end else begin
                    exp_lvl = deb_q.pop_front();
                    check("deb_level", deb, exp_lvl);
                end
                $display("[%0t] debounced -> %0b (change %0d)", $time, deb, deb_changes);
            end
            deb_prev = deb;
        end
    end

    // Called at a negedge; returns just after the accepting edge.
    task automatic issue(input logic lvl, input int lat, input logic chk_head,
                         input logic [5:0] head, input logic push);
        exp_t e;
        int   k;
        k = 0;
        while (!bif.o_req_ready && k < 100) begin @(negedge clk); k++; end
        check("ready_before_issue", bif.o_req_ready, 1);
        if (push) begin
            model_req(lvl, e);
            e.latency = lat; e.chk_head = chk_head; e.head = head;
            sb_q.push_back(e);
        end
        bif.i_req_level = lvl;
        bif.i_req_valid = 1'b1;
        @(posedge clk);
        #1 bif.i_req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (!bif.o_done && k < 50);
        check("done_seen", bif.o_done, 1);
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int k;
        bif.i_req_valid  = 1'b1; bif.i_req_level  = 1'b1;
        bif2.i_req_valid = 1'b0; bif2.i_req_level = 1'b0;
        bif3.i_req_valid = 1'b0; bif3.i_req_level = 1'b0;

        // Reset held with a pending request: nothing may be accepted.
        repeat (3) begin
            @(negedge clk);
            check("rst_btn", bif.o_btn, 0);
            check("rst_ready", bif.o_req_ready, 1);
            check("rst_done", bif.o_done, 0);
        end
        bif.i_req_valid = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);

        // Null request, then the first bouncing request shows the seed pattern.
        issue(1'b0, 1, 1'b0, 6'b0, 1'b1);
        wait_done();
        @(negedge clk);
        check("null_ready_back", bif.o_req_ready, 1);
        issue(1'b1, BC + 1, 1'b1, 6'b101011, 1'b1);
        wait_done();
        issue(1'b0, BC + 1, 1'b0, 6'b0, 1'b1);   // back-to-back in the done cycle
        wait_done();
        repeat (3) @(negedge clk);

        // Abort mid-bounce; the LFSR restarts so the pattern repeats.
        issue(1'b1, 0, 1'b0, 6'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_btn", bif.o_btn, 0);
        check("abort_ready", bif.o_req_ready, 1);
        check("abort_done", bif.o_done, 0);
        m_lfsr = 16'hACE1; m_btn = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        issue(1'b1, BC + 1, 1'b1, 6'b101011, 1'b1);
        wait_done();
        issue(1'b0, BC + 1, 1'b0, 6'b0, 1'b1);
        wait_done();

        // Single-cycle window: one visible edge, then done.
        @(negedge clk);
        bif3.i_req_level = 1'b1; bif3.i_req_valid = 1'b1;
        @(posedge clk); #1 bif3.i_req_valid = 1'b0;
        @(negedge clk);
        check("bc1_btn_after_accept", bif3.o_btn, 1);
        check("bc1_ready_low", bif3.o_req_ready, 0);
        check("bc1_no_done_yet", bif3.o_done, 0);
        @(negedge clk);
        check("bc1_btn_settled", bif3.o_btn, 1);
        check("bc1_done", bif3.o_done, 1);
        check("bc1_ready_back", bif3.o_req_ready, 1);
        @(negedge clk);
        check("bc1_done_one_cycle", bif3.o_done, 0);

        // Closed loop: alternating requests through the debouncer.
        for (int i = 0; i < 20; i++) begin
            k = 0;
            while (!bif2.o_req_ready && k < 100) begin @(negedge clk); k++; end
            check("loop_ready", bif2.o_req_ready, 1);
            deb_q.push_back(i % 2 == 0);
            bif2.i_req_level = (i % 2 == 0);
            bif2.i_req_valid = 1'b1;
            @(posedge clk); #1 bif2.i_req_valid = 1'b0;
            k = 0;
            do begin @(negedge clk); k++; end while (!bif2.o_done && k < BC2 + 50);
            check("loop_done_seen", bif2.o_done, 1);
            repeat (TP + 20) @(negedge clk);
            $display("[%0t] loop req %0d level=%0b debounced=%0b", $time, i, bif2.i_req_level, deb);
        end

        check("sb_drained", sb_q.size(), 0);
        check("deb_drained", deb_q.size(), 0);
        check("deb_change_count", deb_changes, 20);
        check("deb_final_level", deb, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
